mcm_pipe: RTL and testbench
===========================

// Module: mcm_pipe
// PURPOSE
//  Pipelined, parametrised multiple-constant multiplier bank for the intra angular filter datapath.
//  Each beat carries LANES unsigned reference samples and a 2-bit coefficient-set index.
//  Every lane is multiplied by the NUM_PROD constants of the selected set, using shift-add only.
//  Sits between the reference-sample fetch and the averaging/filter adder tree.
//  valid/ready on both sides; throughput of 1 beat per clock.
// PARAMETERS
//  SAMPLE_W  8   input sample width (unsigned)
//  LANES     4   samples per beat
//  NUM_PROD  6   products per lane (1..6); uses the first NUM_PROD columns of the coefficient table
//  OUT_W     16  signed product width
// PORTS
//  clk        in   1                        rising-edge clock
//  rst_n      in   1                        synchronous, active-low reset
//  in_valid   in   1                        input beat valid
//  in_ready   out  1                        input beat accepted when in_valid && in_ready
//  in_set     in   2                        coefficient-set index, sampled per beat
//  in_last    in   1                        end-of-block marker, passed through
//  in_x       in   LANES*SAMPLE_W           lane l = in_x[l*SAMPLE_W +: SAMPLE_W]
//  out_valid  out  1                        output beat valid
//  out_ready  in   1                        downstream accept
//  out_last   out  1                        in_last of this beat
//  out_y      out  LANES*NUM_PROD*OUT_W     out_y[(l*NUM_PROD+k)*OUT_W +: OUT_W] = x_l * COEF[set][k]
//  beat_cnt   out  16                       count of accepted output beats, wraps at 2^16
// BEHAVIOUR
//  - Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
//  - Reset values: out_valid=0, out_last=0, out_y=0, beat_cnt=0, internal valids=0.
//    in_ready is 1 in the first cycle after reset.
//  - Pipeline stage A registers x, set and last (valid_a). Stage B registers the products (valid_b).
//  - Advance rules:
//    - en_b = !valid_b || out_ready
//    - en_a = !valid_a || en_b
//    - in_ready = en_a, which is combinational from out_ready
//  - Latency: 2 cycles from accept to out_valid when out_ready is held high.
//  - Stall: while out_valid && !out_ready, out_y, out_last and out_valid hold stable.
//    No beat is dropped or duplicated. Up to 2 beats are held in flight.
//  - The set index travels with its beat. Changing in_set every beat is legal and
//    produces no cross-beat mixing.
//  - Arithmetic: x is zero-extended and the coefficient is signed, giving an exact
//    product of SAMPLE_W+8 bits. This is reduced to OUT_W per CONFIGURATION.
//  - Coefficient table COEF[4][6]; all |c| <= 64; constant, shift-add only, no multipliers:
//    - set0 {-3, 8, 36, 24, 34, 23}
//    - set1 {-2, 6, 58, -1,  8, 64}
//    - set2 {-4, 28, 44, -4, 14, 51}
//    - set3 {-2, 0, 63,  1, -6, -1}
//  - beat_cnt increments on out_valid && out_ready only.
//  - Reset asserted mid-stream: all in-flight beats are discarded and nothing is emitted
//    after rst_n rises. beat_cnt returns to 0.
//  - Input held with in_valid=1 while in_ready=0: it is not accepted, and is captured
//    exactly once when in_ready rises.
// CONFIGURATION
//  MCM_SAT_EN defined: the product is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  MCM_SAT_EN undefined: the low OUT_W bits are kept (two's-complement wrap).
//  Identical when OUT_W >= SAMPLE_W+8.
// STRUCTURE
//  Package mcm_pkg:
//    - COEF_NSETS=4 and COEF_NPROD=6
//    - the signed 8-bit COEF table
//    - typedef coef_set_t (2-bit)
//    - function sat_trunc(product, OUT_W)
//  Sub-module mcm_lane (purely combinational):
//    - one sample, one set index -> NUM_PROD products
//    - shared shift-add terms (x, 3x, 9x, 17x, ...) muxed by set
//    - instantiated LANES times in stage B
//  Top level owns the handshake, the stage registers and beat_cnt.
// TESTING
//  1. Reset, then lane0 x=10, set0, out_ready=1 -> after 2 cycles products -30,80,360,240,340,230; beat_cnt=1.
//  2. x=255 on all lanes, set0 -> -765,2040,9180,6120,8670,5865 on every lane.
//  3. OUT_W=12, x=255, set0, product k=2:
//     - with MCM_SAT_EN -> 2047
//     - without -> 988 (wrap)
//  4. Stream 8 beats with set cycling 0..3; out_ready low for 3 cycles mid-stream ->
//     - outputs hold stable during the stall
//     - in_ready=0 once 2 beats are held
//     - all 8 beats emerge in order with correct sets
//  5. rst_n low for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, beat_cnt=0, no stale beat emitted later.
//  6. 65537 accepted beats -> beat_cnt wraps to 1; out_last tracks in_last on every beat.

Source files
------------

// File: rtl/mcm_pkg.sv
// Shared constants, coefficient table and product reduction for the mcm_pipe multiplier bank.
// MCM_SAT_EN: when defined, sat_trunc clamps to the output range instead of wrapping.
package mcm_pkg;

  localparam int unsigned COEF_NSETS = 4;
  localparam int unsigned COEF_NPROD = 6;

  typedef logic [1:0] coef_set_t;

  localparam logic signed [7:0] COEF [COEF_NSETS][COEF_NPROD] = '{
    '{-8'sd3,  8'sd8,  8'sd36,  8'sd24,  8'sd34,  8'sd23},
    '{-8'sd2,  8'sd6,  8'sd58, -8'sd1,   8'sd8,   8'sd64},
    '{-8'sd4,  8'sd28, 8'sd44, -8'sd4,   8'sd14,  8'sd51},
    '{-8'sd2,  8'sd0,  8'sd63,  8'sd1,  -8'sd6,  -8'sd1}
  };

  // Reduce an exact product to out_w bits (1..31), returned sign-extended to 32 bits.
  function automatic logic signed [31:0] sat_trunc(input logic signed [31:0] product,
                                                   input int unsigned out_w);
    logic signed [31:0] res;
`ifdef MCM_SAT_EN
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (product > hi) begin
      res = hi;
    end else if (product < lo) begin
      res = lo;
    end else begin
      res = product;
    end
`else
    res = (product <<< (32 - out_w)) >>> (32 - out_w);
`endif
    return res;
  endfunction

endpackage

// File: rtl/mcm_lane.sv
// One sample times the constants of the selected coefficient set, built from shared shift-add terms.
module mcm_lane
  import mcm_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned NUM_PROD = 6
) (
  input  logic [SAMPLE_W-1:0]                x,
  input  logic [1:0]                         set,
  output logic [NUM_PROD*(SAMPLE_W+8)-1:0]   prod
);

  localparam int unsigned PW = SAMPLE_W + 8;

  logic signed [PW-1:0] x1;
  logic signed [PW-1:0] x3;
  logic signed [PW-1:0] x9;
  logic signed [PW-1:0] x17;
  logic signed [PW-1:0] p [COEF_NPROD];

  always_comb begin
    x1  = signed'(PW'(x));
    x3  = (x1 <<< 1) + x1;
    x9  = (x1 <<< 3) + x1;
    x17 = (x1 <<< 4) + x1;
    p   = '{default: '0};
    prod = '0;
    case (set)
      2'd0: begin
        p[0] = -x3;
        p[1] = x1 <<< 3;
        p[2] = x9 <<< 2;
        p[3] = x3 <<< 3;
        p[4] = x17 <<< 1;
        p[5] = (x3 <<< 3) - x1;
      end
      2'd1: begin
        p[0] = -(x1 <<< 1);
        p[1] = x3 <<< 1;
        p[2] = (x1 <<< 6) - (x3 <<< 1);
        p[3] = -x1;
        p[4] = x1 <<< 3;
        p[5] = x1 <<< 6;
      end
      2'd2: begin
        p[0] = -(x1 <<< 2);
        p[1] = (x1 <<< 5) - (x1 <<< 2);
        p[2] = (x1 <<< 5) + (x3 <<< 2);
        p[3] = -(x1 <<< 2);
        p[4] = (x1 <<< 4) - (x1 <<< 1);
        p[5] = (x17 <<< 1) + x17;
      end
      default: begin
        p[0] = -(x1 <<< 1);
        p[1] = '0;
        p[2] = (x1 <<< 6) - x1;
        p[3] = x1;
        p[4] = -(x3 <<< 1);
        p[5] = -x1;
      end
    endcase
    for (int unsigned k = 0; k < NUM_PROD; k++) begin
      prod[k*PW +: PW] = p[k];
    end
  end

endmodule

// File: rtl/mcm_pipe.sv
// Two-stage valid/ready multiple-constant multiplier bank (stage A: inputs, stage B: products).
// MCM_SAT_EN: when defined, products saturate to OUT_W bits; otherwise they wrap.
module mcm_pipe
  import mcm_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned NUM_PROD = 6,
  parameter int unsigned OUT_W    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      in_set,
  input  logic                            in_last,
  input  logic [LANES*SAMPLE_W-1:0]       in_x,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [LANES*NUM_PROD*OUT_W-1:0] out_y,
  output logic [15:0]                     beat_cnt
);

  localparam int unsigned PW = SAMPLE_W + 8;
  localparam int unsigned YW = LANES * NUM_PROD * OUT_W;

  logic                      valid_a_q, valid_a_d;
  logic [LANES*SAMPLE_W-1:0] x_a_q, x_a_d;
  coef_set_t                 set_a_q, set_a_d;
  logic                      last_a_q, last_a_d;
  logic                      valid_b_q, valid_b_d;
  logic [YW-1:0]             y_b_q, y_b_d;
  logic                      last_b_q, last_b_d;
  logic [15:0]               beat_cnt_q, beat_cnt_d;
  logic                      en_a, en_b;

  logic [NUM_PROD*PW-1:0]    lane_p [LANES];
  logic signed [PW-1:0]      prod_s;
  logic signed [31:0]        red;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mcm_lane #(
      .SAMPLE_W (SAMPLE_W),
      .NUM_PROD (NUM_PROD)
    ) u_lane (
      .x    (x_a_q[l*SAMPLE_W +: SAMPLE_W]),
      .set  (set_a_q),
      .prod (lane_p[l])
    );
  end

  // in_ready is combinational from out_ready so a full pipe still streams 1 beat/clock.
  always_comb begin
    en_b       = !valid_b_q || out_ready;
    en_a       = !valid_a_q || en_b;
    valid_a_d  = valid_a_q;
    x_a_d      = x_a_q;
    set_a_d    = set_a_q;
    last_a_d   = last_a_q;
    valid_b_d  = valid_b_q;
    y_b_d      = y_b_q;
    last_b_d   = last_b_q;
    prod_s     = '0;
    red        = '0;
    beat_cnt_d = beat_cnt_q + 16'(valid_b_q && out_ready);

    if (en_a) begin
      valid_a_d = in_valid;
      if (in_valid) begin
        x_a_d    = in_x;
        set_a_d  = in_set;
        last_a_d = in_last;
      end
    end

    if (en_b) begin
      valid_b_d = valid_a_q;
      if (valid_a_q) begin
        last_b_d = last_a_q;
        for (int unsigned l = 0; l < LANES; l++) begin
          for (int unsigned k = 0; k < NUM_PROD; k++) begin
            prod_s = lane_p[l][k*PW +: PW];
            red    = sat_trunc(32'(prod_s), OUT_W);
            y_b_d[(l*NUM_PROD+k)*OUT_W +: OUT_W] = red[OUT_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_a_q  <= 1'b0;
      x_a_q      <= '0;
      set_a_q    <= '0;
      last_a_q   <= 1'b0;
      valid_b_q  <= 1'b0;
      y_b_q      <= '0;
      last_b_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      valid_a_q  <= valid_a_d;
      x_a_q      <= x_a_d;
      set_a_q    <= set_a_d;
      last_a_q   <= last_a_d;
      valid_b_q  <= valid_b_d;
      y_b_q      <= y_b_d;
      last_b_q   <= last_b_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign in_ready  = en_a;
  assign out_valid = valid_b_q;
  assign out_last  = last_b_q;
  assign out_y     = y_b_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mcm_pipe.sv
// Scoreboard bench for mcm_pipe: a 16-bit and a 12-bit output instance share one input stream.
module tb_mcm_pipe;

  localparam int unsigned SW   = 8;
  localparam int unsigned LN   = 4;
  localparam int unsigned NP   = 6;
  localparam int unsigned OW   = 16;
  localparam int unsigned OW12 = 12;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_last   = 1'b0;
  logic              out_ready = 1'b0;
  logic [1:0]        in_set    = '0;
  logic [LN*SW-1:0]  in_x      = '0;

  logic                  in_ready, out_valid, out_last;
  logic [LN*NP*OW-1:0]   out_y;
  logic [15:0]           beat_cnt;
  logic                  in_ready12, out_valid12, out_last12;
  logic [LN*NP*OW12-1:0] out_y12;
  logic [15:0]           beat_cnt12;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [LN*SW-1:0] x;
    logic [1:0]       set;
    logic             last;
  } beat_t;

  beat_t sb[$];
  beat_t b;

  int coef [4][6] = '{
    '{-3,  8, 36, 24, 34, 23},
    '{-2,  6, 58, -1,  8, 64},
    '{-4, 28, 44, -4, 14, 51},
    '{-2,  0, 63,  1, -6, -1}
  };

  always #5 clk = ~clk;

  mcm_pipe #(.SAMPLE_W(SW), .LANES(LN), .NUM_PROD(NP), .OUT_W(OW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_set(in_set),
    .in_last(in_last), .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_y(out_y), .beat_cnt(beat_cnt)
  );

  mcm_pipe #(.SAMPLE_W(SW), .LANES(LN), .NUM_PROD(NP), .OUT_W(OW12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12), .in_set(in_set),
    .in_last(in_last), .in_x(in_x), .out_valid(out_valid12), .out_ready(out_ready),
    .out_last(out_last12), .out_y(out_y12), .beat_cnt(beat_cnt12)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_prod(input logic [SW-1:0] x, input logic [1:0] s,
                                      input int k, input int unsigned ow);
    longint p, hi, lo, span;
    p    = longint'(x) * longint'(coef[s][k]);
    span = longint'(1) <<< ow;
    hi   = (span >>> 1) - 1;
    lo   = -(span >>> 1);
`ifdef MCM_SAT_EN
    if (p > hi) p = hi;
    else if (p < lo) p = lo;
`else
    p = p & (span - 1);
    if (p > hi) p = p - span;
`endif
    return p;
  endfunction

  logic [LN*NP*OW-1:0] prev_y;
  logic                prev_last  = 1'b0;
  logic                prev_stall = 1'b0;
  logic [15:0]         model_cnt  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      model_cnt  = '0;
      prev_stall = 1'b0;
    end else begin
      check("beat_cnt", beat_cnt, model_cnt);
      check("beat_cnt12", beat_cnt12, model_cnt);
      check("in_ready12", in_ready12, in_ready);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_y", out_y, prev_y);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("stray_beat", out_valid, 0);
        end else begin
          b = sb.pop_front();
          check("valid12", out_valid12, 1);
          check("last", out_last, b.last);
          check("last12", out_last12, b.last);
          for (int l = 0; l < LN; l++) begin
            for (int k = 0; k < NP; k++) begin
              check("y16", $signed(out_y[(l*NP+k)*OW +: OW]),
                    exp_prod(b.x[l*SW +: SW], b.set, k, OW));
              check("y12", $signed(out_y12[(l*NP+k)*OW12 +: OW12]),
                    exp_prod(b.x[l*SW +: SW], b.set, k, OW12));
            end
          end
          model_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      prev_last  = out_last;
      if (in_valid && in_ready) sb.push_back('{x: in_x, set: in_set, last: in_last});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [LN*SW-1:0] x, input logic [1:0] s, input logic last);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_x     = x;
    in_set   = s;
    in_last  = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_y_any", |out_y, 0);
    check("rst_cnt", beat_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    tick(1);

    // Single beat, lane0 x=10, set0: latency and count
    send({24'd0, 8'd10}, 2'd0, 1'b1);
    @(negedge clk);
    check("lat_early", out_valid, 0);
    @(negedge clk);
    check("lat_2cyc", out_valid, 1);
    @(posedge clk);
    @(negedge clk);
    check("cnt_one", beat_cnt, 1);
    tick(1);

    // Full-scale samples, set0 (12-bit instance exercises wrap or clamp)
    send({4{8'd255}}, 2'd0, 1'b0);
    tick(4);

    // Streaming with a 3-cycle downstream stall
    fork
      for (int i = 0; i < 8; i++) begin
        send({8'(i * 31 + 7), 8'(i * 53 + 1), 8'(255 - i * 17), 8'(i * 29)}, 2'(i), i == 7);
      end
      begin
        tick(3);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    tick(6);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send({4{8'd100}}, 2'd1, 1'b0);
    send({4{8'd200}}, 2'd2, 1'b1);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_cnt", beat_cnt, 0);
    tick(1);
    out_ready = 1'b1;
    tick(6);

    // 65537 beats: counter wraps to 1
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 65537; i++) begin
      send($urandom(), 2'($urandom_range(3)), 1'($urandom_range(1)));
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    check("drain", sb.size(), 0);
    @(negedge clk);
    check("cnt_wrap", beat_cnt, 1);
    check("cnt_wrap12", beat_cnt12, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
